datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 fast_clock  input  1  the single clock; all state updates on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately while high.
REQ-003 load_pcard1, load_pcard2, load_pcard3  input  1 each  capture the current card into player card register 1/2/3.
REQ-004 load_dcard1, load_dcard2, load_dcard3  input  1 each  capture the current card into dealer card register 1/2/3.
REQ-005 pcard3_out  output  4  player card 3 register value (raw card code 0..13).
REQ-006 pscore_out  output  4  player hand score 0..9.
REQ-007 dscore_out  output  4  dealer hand score 0..9.
REQ-008 HEX0..HEX5  output  7 each  active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}.
REQ-009 No parameters; all widths are fixed as listed.

Function
REQ-010 Card code: 4-bit; 0 = no card, 1 = Ace, 2..9 = pip, 10 = Ten, 11 = Jack, 12 = Queen, 13 = King; codes 14..15 never produced.
REQ-011 Internal deal counter (4-bit) advances by 1 on every rising edge, regardless of loads; 13 wraps to 1; it never holds 0, 14 or 15.
REQ-012 Current card = deal counter value before the edge; a load asserted at an edge stores that value into its register.
REQ-013 Six 4-bit card registers (pcard1..3, dcard1..3); each updates only on a rising edge with its load high, otherwise holds.
REQ-014 Load held high for N edges reloads the register on each of those edges; the last capture wins.
REQ-015 Several loads high at the same edge all capture the same card value.
REQ-016 Card value for scoring: codes 1..9 count at face value; codes 0 and 10..15 count 0.
REQ-017 pscore_out = (val(pcard1)+val(pcard2)+val(pcard3)) mod 10; dscore_out likewise from dcard1..3.
REQ-018 Scores are purely combinational from the registers; valid in the same cycle a register changes (no extra latency).
REQ-019 Display map: HEX0 = pcard1, HEX1 = pcard2, HEX2 = pcard3, HEX3 = dcard1, HEX4 = dcard2, HEX5 = dcard3; combinational.
REQ-020 Segment codes: 0 or 14..15 = 1111111 (blank); 1 = 0001000; 2 = 0100100; 3 = 0110000; 4 = 0011001; 5 = 0010010; 6 = 0000010; 7 = 1111000; 8 = 0000000; 9 = 0010000; 10 = 1000000; 11 = 1100001; 12 = 0011000; 13 = 0001001.
REQ-021 No card code produces the "F" pattern 0001110.

Reset
REQ-022 While reset is high: all six card registers = 0, deal counter = 1, pscore_out = 0, dscore_out = 0, pcard3_out = 0, HEX0..HEX5 = 1111111.
REQ-023 Reset takes effect asynchronously, including mid-deal with loads high; loads are ignored while reset is high.
REQ-024 First rising edge after reset deassertion captures card 1 for any asserted load.

Verification
REQ-025 Assert reset with all loads low -> all card registers 0, both scores 0, all HEX 1111111.
REQ-026 After reset, load_pcard1 high for edge 1 only, then two idle edges -> pcard1 = 1, HEX0 = 0001000, pscore_out = 1, pcard1 unchanged by the idle edges.
REQ-027 After reset, load_pcard1 at edge 1, load_pcard2 at edge 2, load_pcard3 at edge 3 -> cards 1,2,3, pscore_out = 6, pcard3_out = 3, HEX2 = 0110000.
REQ-028 After reset, idle 9 edges, load_dcard1 at edge 10, load_dcard2 at edge 11, load_dcard3 at edge 13 -> dcards 10,11,13, dscore_out = 0, HEX3 = 1000000, HEX4 = 1100001, HEX5 = 0001001.
REQ-029 After reset, idle 13 edges, load_pcard1 and load_dcard1 together at edge 14 -> both = 1 (wrap), pscore_out = dscore_out = 1.
REQ-030 Assert reset asynchronously between edges after cards are loaded -> all outputs return to reset values immediately without a clock edge.

Source files
------------

// File: rtl/datapath.sv
// ---------------------------------------------------------------------------
// datapath -- card-dealing datapath for a baccarat-style game.
//
// A free-running deal counter cycles 1..13 on every rising edge. The value
// it holds before an edge is the "current card"; any load strobe high at that
// edge copies the current card into the matching player/dealer register.
// Hand scores and seven-segment patterns are combinational from the card
// registers, so they follow a register change with no extra latency.
//
// Ports
//   fast_clock          in   clock, all state on rising edge
//   reset               in   asynchronous active-high reset
//   load_pcard1..3      in   capture current card into player card 1..3
//   load_dcard1..3      in   capture current card into dealer card 1..3
//   pcard3_out  [3:0]   out  player card 3 raw code (0..13)
//   pscore_out  [3:0]   out  player score 0..9
//   dscore_out  [3:0]   out  dealer score 0..9
//   HEX0..HEX5  [6:0]   out  active-low segments {g,f,e,d,c,b,a}:
//                            HEX0..2 = pcard1..3, HEX3..5 = dcard1..3
// ---------------------------------------------------------------------------
module datapath (
    input  logic       fast_clock,
    input  logic       reset,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard3_out,
    output logic [3:0] pscore_out,
    output logic [3:0] dscore_out,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    // Scoring value of a card: pips at face value, tens and faces (and the
    // empty slot / unused codes) count zero.
    function automatic logic [4:0] card_val(input logic [3:0] code);
        logic [4:0] v;
        if ((code >= 4'd1) && (code <= 4'd9)) begin
            v = {1'b0, code};
        end else begin
            v = 5'd0;
        end
        return v;
    endfunction

    // Sum of three card values is at most 27, so two conditional
    // subtractions are enough to reduce modulo 10.
    function automatic logic [3:0] mod10(input logic [4:0] s);
        logic [4:0] r;
        if (s >= 5'd20) begin
            r = s - 5'd20;
        end else if (s >= 5'd10) begin
            r = s - 5'd10;
        end else begin
            r = s;
        end
        return r[3:0];
    endfunction

    // Active-low segment pattern {g,f,e,d,c,b,a} for a card code.
    // Ten is shown as "0"; J, q, K-ish glyphs for faces; empty slot blank.
    function automatic logic [6:0] seg7(input logic [3:0] code);
        logic [6:0] p;
        case (code)
            4'd1:    p = 7'b0001000;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            4'd10:   p = 7'b1000000;
            4'd11:   p = 7'b1100001;
            4'd12:   p = 7'b0011000;
            4'd13:   p = 7'b0001001;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    logic [3:0] deal_q,   deal_d;
    logic [3:0] pcard1_q, pcard1_d;
    logic [3:0] pcard2_q, pcard2_d;
    logic [3:0] pcard3_q, pcard3_d;
    logic [3:0] dcard1_q, dcard1_d;
    logic [3:0] dcard2_q, dcard2_d;
    logic [3:0] dcard3_q, dcard3_d;

    // Deal counter next state: 1..13, wrapping 13 back to 1 (never 0).
    always_comb begin
        deal_d = deal_q;
        if (deal_q >= 4'd13) begin
            deal_d = 4'd1;
        end else begin
            deal_d = deal_q + 4'd1;
        end
    end

    // Card register next state: capture the current card when loaded.
    always_comb begin
        pcard1_d = pcard1_q;
        pcard2_d = pcard2_q;
        pcard3_d = pcard3_q;
        dcard1_d = dcard1_q;
        dcard2_d = dcard2_q;
        dcard3_d = dcard3_q;
        if (load_pcard1) pcard1_d = deal_q; else pcard1_d = pcard1_q;
        if (load_pcard2) pcard2_d = deal_q; else pcard2_d = pcard2_q;
        if (load_pcard3) pcard3_d = deal_q; else pcard3_d = pcard3_q;
        if (load_dcard1) dcard1_d = deal_q; else dcard1_d = dcard1_q;
        if (load_dcard2) dcard2_d = deal_q; else dcard2_d = deal_q & 4'd0 | dcard2_q;
        if (load_dcard3) dcard3_d = deal_q; else dcard3_d = dcard3_q;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge fast_clock or posedge reset) begin
        if (reset) begin
            deal_q   <= 4'd1;
            pcard1_q <= 4'd0;
            pcard2_q <= 4'd0;
            pcard3_q <= 4'd0;
            dcard1_q <= 4'd0;
            dcard2_q <= 4'd0;
            dcard3_q <= 4'd0;
        end else begin
            deal_q   <= deal_d;
            pcard1_q <= pcard1_d;
            pcard2_q <= pcard2_d;
            pcard3_q <= pcard3_d;
            dcard1_q <= dcard1_d;
            dcard2_q <= dcard2_d;
            dcard3_q <= dcard3_d;
        end
    end

    // Combinational scores and display decode straight from the registers.
    always_comb begin
        pcard3_out = pcard3_q;
        pscore_out = mod10(card_val(pcard1_q) + card_val(pcard2_q) + card_val(pcard3_q));
        dscore_out = mod10(card_val(dcard1_q) + card_val(dcard2_q) + card_val(dcard3_q));
        HEX0       = seg7(pcard1_q);
        HEX1       = seg7(pcard2_q);
        HEX2       = seg7(pcard3_q);
        HEX3       = seg7(dcard1_q);
        HEX4       = seg7(dcard2_q);
        HEX5       = seg7(dcard3_q);
    end

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

    logic       fast_clock;
    logic       reset;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic [3:0] pcard3_out, pscore_out, dscore_out;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    datapath dut (
        .fast_clock (fast_clock),
        .reset      (reset),
        .load_pcard1(load_pcard1),
        .load_pcard2(load_pcard2),
        .load_pcard3(load_pcard3),
        .load_dcard1(load_dcard1),
        .load_dcard2(load_dcard2),
        .load_dcard3(load_dcard3),
        .pcard3_out (pcard3_out),
        .pscore_out (pscore_out),
        .dscore_out (dscore_out),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5)
    );

    initial fast_clock = 1'b0;
    always #5 fast_clock = ~fast_clock;

    int checks = 0;
    int errors = 0;

    // Reference model: cards[0..2] = player 1..3, cards[3..5] = dealer 1..3.
    int cards [6];
    int edges;   // rising edges seen since reset released

    logic [6:0] hex_a [6];
    assign hex_a[0] = HEX0;
    assign hex_a[1] = HEX1;
    assign hex_a[2] = HEX2;
    assign hex_a[3] = HEX3;
    assign hex_a[4] = HEX4;
    assign hex_a[5] = HEX5;

    // Segment table taken from the display definition, indexed by card code.
    logic [6:0] seg_tab [16];
    initial begin
        seg_tab[0]  = 7'b1111111; seg_tab[1]  = 7'b0001000;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b1000000; seg_tab[11] = 7'b1100001;
        seg_tab[12] = 7'b0011000; seg_tab[13] = 7'b0001001;
        seg_tab[14] = 7'b1111111; seg_tab[15] = 7'b1111111;
    end

    function automatic int val(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    function automatic int score(input int base);
        return (val(cards[base]) + val(cards[base+1]) + val(cards[base+2])) % 10;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) cards[i] = 0;
        edges = 0;
    endtask

    // Drive the given loads for one rising edge and update the model.
    // Edge number k after reset (k = 1,2,...) deals card ((k-1) mod 13) + 1.
    task automatic tick(input logic [5:0] ld);
        int card;
        {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = ld;
        @(posedge fast_clock);
        card = (edges % 13) + 1;
        edges++;
        for (int i = 0; i < 6; i++) if (ld[i]) cards[i] = card;
        #1;
        {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = 6'b0;
    endtask

    // Pulse reset away from a clock edge; caller is just after a rising edge.
    task automatic pulse_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = 6'b0;
        @(posedge fast_clock);
        #1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (hex_a[i] !== 7'b1111111) begin
                errors++;
                $display("FAIL reset_hex%0d got %b want 1111111", i, hex_a[i]);
            end
        end
        checks++;
        if (pscore_out !== 4'd0 || dscore_out !== 4'd0 || pcard3_out !== 4'd0) begin
            errors++;
            $display("FAIL reset_scores got p=%0d d=%0d pc3=%0d want 0 0 0", pscore_out, dscore_out, pcard3_out);
        end
        #3;
        reset = 1'b0;
    endtask

    task automatic test_single_load();
        pulse_reset();
        tick(6'b000001);
        checks++;
        if (HEX0 !== 7'b0001000 || pscore_out !== 4'd1) begin
            errors++;
            $display("FAIL single_load got hex0=%b p=%0d want 0001000 1", HEX0, pscore_out);
        end
        tick(6'b0);
        tick(6'b0);
        checks++;
        if (HEX0 !== 7'b0001000 || pscore_out !== 4'd1) begin
            errors++;
            $display("FAIL single_hold got hex0=%b p=%0d want 0001000 1", HEX0, pscore_out);
        end
    endtask

    task automatic test_player_sequence();
        pulse_reset();
        tick(6'b000001);
        tick(6'b000010);
        tick(6'b000100);
        checks++;
        if (pscore_out !== 4'd6 || pcard3_out !== 4'd3 || HEX2 !== 7'b0110000 ||
            HEX0 !== 7'b0001000 || HEX1 !== 7'b0100100) begin
            errors++;
            $display("FAIL player_seq got p=%0d pc3=%0d hex2=%b want 6 3 0110000", pscore_out, pcard3_out, HEX2);
        end
    endtask

    task automatic test_dealer_faces();
        pulse_reset();
        repeat (9) tick(6'b0);
        tick(6'b001000);
        tick(6'b010000);
        tick(6'b0);
        tick(6'b100000);
        checks++;
        if (dscore_out !== 4'd0 || HEX3 !== 7'b1000000 || HEX4 !== 7'b1100001 || HEX5 !== 7'b0001001) begin
            errors++;
            $display("FAIL dealer_faces got d=%0d hex3=%b hex4=%b hex5=%b want 0 1000000 1100001 0001001",
                     dscore_out, HEX3, HEX4, HEX5);
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        repeat (13) tick(6'b0);
        tick(6'b001001);
        checks++;
        if (pscore_out !== 4'd1 || dscore_out !== 4'd1 || HEX0 !== 7'b0001000 || HEX3 !== 7'b0001000) begin
            errors++;
            $display("FAIL wrap got p=%0d d=%0d hex0=%b hex3=%b want 1 1 0001000 0001000",
                     pscore_out, dscore_out, HEX0, HEX3);
        end
    endtask

    task automatic test_async_reset();
        pulse_reset();
        repeat (4) tick(6'b0);
        tick(6'b000111);
        tick(6'b111000);
        // Mid-cycle with loads high: outputs must clear without any edge.
        {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = 6'b111111;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (pscore_out !== 4'd0 || dscore_out !== 4'd0 || pcard3_out !== 4'd0 ||
            HEX0 !== 7'b1111111 || HEX5 !== 7'b1111111) begin
            errors++;
            $display("FAIL async_reset got p=%0d d=%0d pc3=%0d hex0=%b hex5=%b want 0 0 0 blank",
                     pscore_out, dscore_out, pcard3_out, HEX0, HEX5);
        end
        // Loads ignored across an edge while reset is high.
        @(posedge fast_clock);
        #1;
        checks++;
        if (pcard3_out !== 4'd0 || HEX3 !== 7'b1111111) begin
            errors++;
            $display("FAIL reset_ignores_load got pc3=%0d hex3=%b want 0 1111111", pcard3_out, HEX3);
        end
        {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = 6'b0;
        #3;
        reset = 1'b0;
        model_reset();
        // First edge after release captures card 1.
        tick(6'b000100);
        checks++;
        if (pcard3_out !== 4'd1) begin
            errors++;
            $display("FAIL first_after_reset got pc3=%0d want 1", pcard3_out);
        end
    endtask

    task automatic test_random();
        logic [5:0] ld;
        pulse_reset();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                pulse_reset();
            end
            for (int i = 0; i < 6; i++) ld[i] = ($urandom_range(0, 3) == 0);
            tick(ld);
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (hex_a[i] !== seg_tab[cards[i]]) begin
                    errors++;
                    $display("FAIL rand_hex%0d step %0d got %b want %b", i, n, hex_a[i], seg_tab[cards[i]]);
                end
                checks++;
                if (hex_a[i] === 7'b0001110) begin
                    errors++;
                    $display("FAIL rand_f_pattern hex%0d step %0d got 0001110", i, n);
                end
            end
            checks++;
            if (pscore_out !== 4'(score(0)) || dscore_out !== 4'(score(3)) || pcard3_out !== 4'(cards[2])) begin
                errors++;
                $display("FAIL rand_score step %0d got p=%0d d=%0d pc3=%0d want %0d %0d %0d",
                         n, pscore_out, dscore_out, pcard3_out, score(0), score(3), cards[2]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_player_sequence();
        test_dealer_faces();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
